// File: rtl/axi4_read_initiator.sv
// axi4_read_initiator
//   AXI4 read master / DMA-style read engine. Each accepted request becomes
//   one INCR burst. Up to MAX_OUTSTANDING bursts can be in flight. Returned
//   beats are buffered in an internal FIFO and streamed to a consumer. A
//   pulse on done_valid reports each finished burst together with its error
//   status.
//
// Ports
//   clock, reset_n          clock, asynchronous active-low reset
//   req_valid/ready         request handshake
//   req_addr, req_len       burst start byte address, beats-1
//   rdata_valid/ready       consumer beat handshake
//   rdata_data, rdata_last  beat data, last beat of burst (by expected count)
//   done_valid, done_error  one-cycle completion pulse plus error flag
//   axi_ar_*                AXI4 read address channel (initiator side)
//   axi_r_*                 AXI4 read data channel (initiator side)
module axi4_read_initiator #(
  parameter int unsigned ADDR_BITS       = 32,
  parameter int unsigned DATA_BITS       = 64,
  parameter int unsigned ID_BITS         = 5,
  parameter int unsigned AXI_ID          = 0,
  parameter int unsigned FIFO_DEPTH      = 256,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [7:0]           req_len,
  output logic                 rdata_valid,
  input  logic                 rdata_ready,
  output logic [DATA_BITS-1:0] rdata_data,
  output logic                 rdata_last,
  output logic                 done_valid,
  output logic                 done_error,
  output logic                 axi_ar_valid,
  input  logic                 axi_ar_ready,
  output logic [ADDR_BITS-1:0] axi_ar_bits_addr,
  output logic [7:0]           axi_ar_bits_len,
  output logic [2:0]           axi_ar_bits_size,
  output logic [ID_BITS-1:0]   axi_ar_bits_id,
  input  logic                 axi_r_valid,
  output logic                 axi_r_ready,
  input  logic [DATA_BITS-1:0] axi_r_bits_data,
  input  logic [1:0]           axi_r_bits_resp,
  input  logic                 axi_r_bits_last,
  input  logic [ID_BITS-1:0]   axi_r_bits_id
);

  localparam int unsigned SIZE = $clog2(DATA_BITS / 8);
  localparam int unsigned FA_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CR_W = FA_W + 1;
  localparam int unsigned OS_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned LQ_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {
    AR_IDLE,
    AR_WAIT,
    AR_ISSUE
  } ar_state_t;

  // Registered state
  logic                 running;
  ar_state_t            ar_state;
  logic                 ar_valid_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [7:0]           len_q;
  logic [CR_W-1:0]      credits;
  logic [OS_W-1:0]      outstanding;
  logic [OS_W-1:0]      issued;
  logic [7:0]           lq [MAX_OUTSTANDING];
  logic [LQ_W-1:0]      lq_head;
  logic [LQ_W-1:0]      lq_tail;
  logic [7:0]           beat;
  logic                 err_q;
  logic                 done_q;
  logic                 done_err_q;
  logic [DATA_BITS:0]   mem [FIFO_DEPTH];
  logic [FA_W-1:0]      wr_ptr;
  logic [FA_W-1:0]      rd_ptr;
  logic [CR_W-1:0]      fcount;

  // Combinational control
  logic       ar_pending;
  logic       req_fire;
  logic [8:0] burst_beats;
  logic       credit_ok;
  logic       issue;
  logic       ar_fire;
  logic       r_fire;
  logic       burst_open;
  logic [7:0] head_len;
  logic       beat_last;
  logic       r_accept;
  logic       burst_end;
  logic       beat_err;
  logic       fifo_pop;

  function automatic logic [LQ_W-1:0] lq_next(input logic [LQ_W-1:0] p);
    return (p == LQ_W'(MAX_OUTSTANDING - 1)) ? '0 : p + LQ_W'(1);
  endfunction

  assign ar_pending  = (ar_state != AR_IDLE);
  assign req_ready   = running && !ar_pending && (outstanding < OS_W'(MAX_OUTSTANDING));
  assign req_fire    = req_valid && req_ready;
  assign burst_beats = {1'b0, len_q} + 9'd1;
  // FIFO space is reserved for the whole burst before AR goes out, so an
  // issued burst can always be absorbed with axi_r_ready tied high.
  assign credit_ok   = (credits >= CR_W'(burst_beats));
  assign issue       = (ar_state == AR_WAIT) && credit_ok;
  assign ar_fire     = ar_valid_q && axi_ar_ready;

  assign axi_r_ready = running;
  assign r_fire      = axi_r_valid && axi_r_ready;
  // A beat belongs to the head burst only once that burst's AR has gone out;
  // bursts issue in request order, so a nonzero issued count is sufficient.
  assign burst_open  = (outstanding != '0) && (issued != '0);
  assign head_len    = lq[lq_head];
  assign beat_last   = (beat == head_len);
  assign r_accept    = r_fire && burst_open;
  assign burst_end   = r_accept && beat_last;
  assign beat_err    = (axi_r_bits_resp != 2'b00)
                    || (axi_r_bits_id != ID_BITS'(AXI_ID))
                    || (axi_r_bits_last != beat_last);

  assign rdata_valid = (fcount != '0);
  assign fifo_pop    = rdata_valid && rdata_ready;
  assign rdata_data  = rdata_valid ? mem[rd_ptr][DATA_BITS-1:0] : '0;
  assign rdata_last  = rdata_valid ? mem[rd_ptr][DATA_BITS] : 1'b0;

  assign axi_ar_valid     = ar_valid_q;
  assign axi_ar_bits_addr = addr_q;
  assign axi_ar_bits_len  = len_q;
  assign axi_ar_bits_size = running ? 3'(SIZE) : 3'd0;
  assign axi_ar_bits_id   = running ? ID_BITS'(AXI_ID) : '0;
  assign done_valid       = done_q;
  assign done_error       = done_err_q;

  // Request capture and AR issue
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      running    <= 1'b0;
      ar_state   <= AR_IDLE;
      ar_valid_q <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
    end else begin
      running <= 1'b1;
      case (ar_state)
        AR_IDLE: begin
          if (req_fire) begin
            addr_q   <= req_addr;
            len_q    <= req_len;
            ar_state <= AR_WAIT;
          end
        end
        AR_WAIT: begin
          if (credit_ok) begin
            ar_valid_q <= 1'b1;
            ar_state   <= AR_ISSUE;
          end
        end
        AR_ISSUE: begin
          if (axi_ar_ready) begin
            ar_valid_q <= 1'b0;
            ar_state   <= AR_IDLE;
          end
        end
        default: begin
          ar_valid_q <= 1'b0;
          ar_state   <= AR_IDLE;
        end
      endcase
    end
  end

  // Credits, in-flight counters and the in-order length queue pointers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      credits     <= CR_W'(FIFO_DEPTH);
      outstanding <= '0;
      issued      <= '0;
      lq_head     <= '0;
      lq_tail     <= '0;
    end else begin
      credits     <= credits - (issue ? CR_W'(burst_beats) : '0) + CR_W'(fifo_pop);
      outstanding <= outstanding + OS_W'(req_fire) - OS_W'(burst_end);
      issued      <= issued + OS_W'(ar_fire) - OS_W'(burst_end);
      if (req_fire) begin
        lq_tail <= lq_next(lq_tail);
      end
      if (burst_end) begin
        lq_head <= lq_next(lq_head);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (req_fire) begin
      lq[lq_tail] <= req_len;
    end
  end

  // Beat tracking and completion reporting
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beat       <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      done_q <= burst_end;
      if (r_accept) begin
        if (beat_last) begin
          beat       <= '0;
          err_q      <= 1'b0;
          done_err_q <= err_q | beat_err;
        end else begin
          beat  <= beat + 8'd1;
          err_q <= err_q | beat_err;
        end
      end
    end
  end

  // Read-data FIFO
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcount <= '0;
    end else begin
      if (r_accept) begin
        wr_ptr <= wr_ptr + FA_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + FA_W'(1);
      end
      fcount <= fcount + CR_W'(r_accept) - CR_W'(fifo_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (r_accept) begin
      mem[wr_ptr] <= {beat_last, axi_r_bits_data};
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(r_accept && (fcount == CR_W'(FIFO_DEPTH))));

  a_no_orphan_beat: assert property (@(posedge clock) disable iff (!reset_n)
    !(r_fire && !burst_open));

endmodule

// File: tb/tb_axi4_read_initiator.sv
// tb_axi4_read_initiator
//   Self-checking bench for axi4_read_initiator. A behavioural AXI slave
//   answers each AR with a programmable burst (error, wrong-id and r_last
//   placement injection). A scoreboard holds the expected AR fields, beats
//   and completion status derived from the requests themselves. Table
//   vectors, hand-written corner sequences and a randomized phase drive it.
`timescale 1ns/1ps
module tb_axi4_read_initiator;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic        rdata_valid;
  logic        rdata_ready;
  logic [63:0] rdata_data;
  logic        rdata_last;
  logic        done_valid;
  logic        done_error;
  logic        axi_ar_valid;
  logic        axi_ar_ready;
  logic [31:0] axi_ar_bits_addr;
  logic [7:0]  axi_ar_bits_len;
  logic [2:0]  axi_ar_bits_size;
  logic [4:0]  axi_ar_bits_id;
  logic        axi_r_valid;
  logic        axi_r_ready;
  logic [63:0] axi_r_bits_data;
  logic [1:0]  axi_r_bits_resp;
  logic        axi_r_bits_last;
  logic [4:0]  axi_r_bits_id;

  always #5 clock = ~clock;

  axi4_read_initiator #(
    .ADDR_BITS(32), .DATA_BITS(64), .ID_BITS(5), .AXI_ID(0),
    .FIFO_DEPTH(256), .MAX_OUTSTANDING(4)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata_data(rdata_data),
    .rdata_last(rdata_last), .done_valid(done_valid), .done_error(done_error),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
    .axi_ar_bits_addr(axi_ar_bits_addr), .axi_ar_bits_len(axi_ar_bits_len),
    .axi_ar_bits_size(axi_ar_bits_size), .axi_ar_bits_id(axi_ar_bits_id),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_bits_data(axi_r_bits_data),
    .axi_r_bits_resp(axi_r_bits_resp), .axi_r_bits_last(axi_r_bits_last),
    .axi_r_bits_id(axi_r_bits_id)
  );

  typedef struct { int err_beat; int last_beat; bit bad_id; } inj_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; inj_t inj; } burst_t;
  typedef struct { logic [63:0] data; logic last; } beat_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; inj_t inj; bit exp_err; } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ar_count = 0;
  int r_count = 0;
  bit r_fired = 0;
  bit track_rr = 0;
  bit rr_dropped = 0;
  bit ar_hold = 0;
  bit ar_rand = 0;
  bit r_hold = 0;
  int r_gap_pct = 0;
  int rready_mode = 1;

  burst_t ar_exp[$];
  burst_t sq[$];
  beat_t  beat_q[$];
  bit     done_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [63:0] beat_data(input logic [31:0] a, input int i);
    return {a, 32'hA0 + 32'(i)};
  endfunction

  function automatic inj_t clean(input int len);
    inj_t r;
    r.err_beat = -1; r.last_beat = len; r.bad_id = 1'b0;
    return r;
  endfunction

  // A burst is in error if any beat has a non-OKAY response, any beat has
  // the wrong ID, or r_last is anywhere other than exactly the final beat.
  function automatic bit model_err(input logic [7:0] len, input inj_t inj);
    return (inj.err_beat >= 0 && inj.err_beat <= int'(len))
        || (inj.last_beat != int'(len)) || inj.bad_id;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic do_req(input logic [31:0] a, input logic [7:0] l, input inj_t inj, input bit exp_err);
    bit ok = 1'b0;
    req_valid = 1'b1; req_addr = a; req_len = l;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clock);
      if (req_ready) begin
        ok = 1'b1;
        ar_exp.push_back('{a, l, inj});
        for (int i = 0; i <= int'(l); i++) beat_q.push_back('{beat_data(a, i), i == int'(l)});
        done_q.push_back(exp_err);
      end
    end
    if (!ok) check("req_timeout", 0, 1);
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((beat_q.size() != 0 || done_q.size() != 0 || ar_exp.size() != 0) && t < budget) begin
      @(negedge clock); t++;
    end
    if (beat_q.size() != 0 || done_q.size() != 0 || ar_exp.size() != 0) begin
      check("idle_timeout", 0, 1);
      ar_exp.delete(); beat_q.delete(); done_q.delete();
    end
    @(posedge clock); #1;
  endtask

  // Slave and consumer drivers, updated just after each active edge.
  initial begin : drivers
    burst_t cur;
    bit active;
    int beat;
    active = 1'b0; beat = 0;
    axi_ar_ready = 1'b0; axi_r_valid = 1'b0; axi_r_bits_data = '0;
    axi_r_bits_resp = '0; axi_r_bits_last = 1'b0; axi_r_bits_id = '0; rdata_ready = 1'b0;
    forever begin
      @(posedge clock); #1;
      case (rready_mode)
        0: rdata_ready = 1'b0;
        1: rdata_ready = 1'b1;
        default: rdata_ready = 1'($urandom_range(0, 1));
      endcase
      if (!reset_n) begin
        sq.delete(); active = 1'b0; beat = 0; r_fired = 1'b0;
        axi_r_valid = 1'b0; axi_ar_ready = 1'b0;
      end else begin
        axi_ar_ready = ar_hold ? 1'b0 : (ar_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        if (r_fired) begin
          r_fired = 1'b0; beat++;
          if (beat > int'(cur.len)) active = 1'b0;
        end
        if (!active && !r_hold && sq.size() > 0) begin
          cur = sq.pop_front(); active = 1'b1; beat = 0;
        end
        if (active && !r_hold && $urandom_range(0, 99) >= r_gap_pct) begin
          axi_r_valid     = 1'b1;
          axi_r_bits_data = beat_data(cur.addr, beat);
          axi_r_bits_resp = (beat == cur.inj.err_beat) ? 2'd2 : 2'd0;
          axi_r_bits_last = (beat == cur.inj.last_beat);
          axi_r_bits_id   = (cur.inj.bad_id && beat == 0) ? 5'd3 : 5'd0;
        end else begin
          axi_r_valid = 1'b0;
        end
      end
    end
  end

  // Observes handshakes mid-cycle; each one completes at the next edge.
  initial begin : monitor
    burst_t b;
    beat_t bt;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (track_rr && !axi_r_ready) rr_dropped = 1'b1;
        if (axi_ar_valid && axi_ar_ready) begin
          ar_count++;
          if (ar_exp.size() == 0) check("ar_unexpected", 1, 0);
          else begin
            b = ar_exp.pop_front();
            check("ar_addr", axi_ar_bits_addr, b.addr);
            check("ar_len", axi_ar_bits_len, b.len);
            check("ar_size", axi_ar_bits_size, 3'd3);
            check("ar_id", axi_ar_bits_id, 5'd0);
            sq.push_back(b);
          end
        end
        if (axi_r_valid && axi_r_ready) begin
          r_fired = 1'b1; r_count++;
        end
        if (rdata_valid && rdata_ready) begin
          if (beat_q.size() == 0) check("rdata_unexpected", 1, 0);
          else begin
            bt = beat_q.pop_front();
            check("rdata_data", rdata_data, bt.data);
            check("rdata_last", rdata_last, bt.last);
          end
        end
        if (done_valid) begin
          if (done_q.size() == 0) check("done_unexpected", 1, 0);
          else check("done_error", done_error, done_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vt[7];
    int base_ar, base_r, pops, pop_cyc, ar_cyc;
    bit stable, any_ready;
    logic [31:0] a0, ra;
    logic [7:0] l0, rl;
    inj_t ri;

    vt[0] = '{32'h0000_1000, 8'd3,   '{-1, 3, 1'b0},   1'b0};
    vt[1] = '{32'h0000_2000, 8'd3,   '{2, 3, 1'b0},    1'b1};
    vt[2] = '{32'h0000_2040, 8'd3,   '{-1, 3, 1'b0},   1'b0};
    vt[3] = '{32'h0000_3000, 8'd3,   '{-1, 1, 1'b0},   1'b1};
    vt[4] = '{32'h0000_4000, 8'd1,   '{-1, 1, 1'b1},   1'b1};
    vt[5] = '{32'h0000_5008, 8'd0,   '{-1, 0, 1'b0},   1'b0};
    vt[6] = '{32'h0000_6000, 8'd255, '{-1, 255, 1'b0}, 1'b0};

    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {req_ready, axi_ar_valid, axi_r_ready, rdata_valid, rdata_last,
                            done_valid, done_error}, 7'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("req_ready_after_reset", req_ready, 1'b1);
    check("r_ready_after_reset", axi_r_ready, 1'b1);

    // Table vectors: single bursts with clean and faulty responses.
    foreach (vt[i]) begin
      do_req(vt[i].addr, vt[i].len, vt[i].inj, vt[i].exp_err);
      wait_idle(2000);
    end

    // AR held off by the slave: channel must stay stable, no new requests.
    @(negedge clock); ar_hold = 1'b1; base_ar = ar_count;
    @(posedge clock); #1;
    do_req(32'h0000_7000, 8'd7, clean(7), 1'b0);
    for (int t = 0; t < 20 && !axi_ar_valid; t++) @(negedge clock);
    a0 = axi_ar_bits_addr; l0 = axi_ar_bits_len;
    stable = axi_ar_valid;
    repeat (5) begin
      @(negedge clock);
      if (!axi_ar_valid || axi_ar_bits_addr != a0 || axi_ar_bits_len != l0 || req_ready) stable = 1'b0;
    end
    check("ar_hold_stable", stable, 1'b1);
    ar_hold = 1'b0;
    wait_idle(2000);
    check("ar_hold_single", ar_count - base_ar, 1);

    // FIFO credits: second 256-beat burst waits until the first fully drains.
    @(negedge clock); rready_mode = 0; track_rr = 1'b1; rr_dropped = 1'b0;
    base_r = r_count; base_ar = ar_count;
    @(posedge clock); #1;
    do_req(32'h0000_8000, 8'd255, clean(255), 1'b0);
    do_req(32'h0000_9000, 8'd255, clean(255), 1'b0);
    for (int t = 0; t < 3000 && (r_count - base_r) < 256; t++) @(negedge clock);
    repeat (10) @(negedge clock);
    check("credit_ar_blocked", axi_ar_valid, 1'b0);
    check("credit_one_ar", ar_count - base_ar, 1);
    check("credit_beats", r_count - base_r, 256);
    check("credit_fifo_valid", rdata_valid, 1'b1);
    check("credit_r_ready_held", rr_dropped, 1'b0);
    rready_mode = 1;
    pops = 0; pop_cyc = -1000; ar_cyc = -1;
    for (int t = 0; t < 1000 && ar_cyc < 0; t++) begin
      @(negedge clock);
      if (rdata_valid && rdata_ready) begin
        pops++;
        if (pops == 256) pop_cyc = cyc;
      end
      if (axi_ar_valid) ar_cyc = cyc;
    end
    check("credit_ar_after_last_pop", ar_cyc - pop_cyc, 2);
    track_rr = 1'b0;
    wait_idle(3000);

    // Outstanding limit, then reset in the middle of a burst.
    @(negedge clock); r_hold = 1'b1; base_ar = ar_count;
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) do_req(32'h0000_A000 + 32'(i * 64), 8'd3, clean(3), 1'b0);
    req_valid = 1'b1; req_addr = 32'h0000_A100; req_len = 8'd3;
    any_ready = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (req_ready) any_ready = 1'b1;
    end
    check("outstanding_limit", any_ready, 1'b0);
    check("outstanding_four_ars", ar_count - base_ar, 4);
    base_r = r_count; r_hold = 1'b0;
    for (int t = 0; t < 100 && (r_count - base_r) < 2; t++) @(negedge clock);
    @(posedge clock); #2;
    reset_n = 1'b0; req_valid = 1'b0;
    #1;
    check("reset_mid_outputs", {req_ready, axi_ar_valid, axi_r_ready, rdata_valid, rdata_last,
                                done_valid, done_error}, 7'd0);
    check("reset_mid_data", {rdata_data, axi_ar_bits_addr, axi_ar_bits_len}, '0);
    ar_exp.delete(); beat_q.delete(); done_q.delete();
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    do_req(32'h0000_B000, 8'd0, clean(0), 1'b0);
    wait_idle(500);

    // Randomized traffic against the scoreboard.
    @(negedge clock); ar_rand = 1'b1; rready_mode = 2; r_gap_pct = 30;
    @(posedge clock); #1;
    for (int n = 0; n < 40; n++) begin
      rl = 8'($urandom_range(0, 15));
      ra = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 255)) << 3);
      ri = clean(int'(rl));
      case ($urandom_range(0, 9))
        0: ri.err_beat = $urandom_range(0, int'(rl));
        1: ri.last_beat = -1;
        2: ri.bad_id = 1'b1;
        default: ;
      endcase
      do_req(ra, rl, ri, model_err(rl, ri));
    end
    wait_idle(6000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4_read_initiator.md
Name: axi4_read_initiator

Overview:
Synthesizable AXI4 read master (DMA-style read engine) that drives the AR/R channels of an AXI4 slave such as the team's simulated DRAM.
- Accepts simple read requests and issues one INCR burst per request, with up to MAX_OUTSTANDING bursts in flight.
- Buffers returned beats in an internal FIFO and streams them to a consumer.
- Reports per-burst completion and error status.

Parameters:
ADDR_BITS, 32, AXI/request address width
DATA_BITS, 64, data width; power of 2, 8..1024
ID_BITS, 5, AXI ID width
AXI_ID, 0, constant ID driven on every AR
FIFO_DEPTH, 256, read-data FIFO entries; power of 2, must be >= 256 so any burst fits
MAX_OUTSTANDING, 4, maximum accepted-but-incomplete bursts

Ports:
clock  input  1  clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  read request valid
req_ready  output  1  read request ready
req_addr  input  ADDR_BITS  burst start byte address
req_len  input  8  beats minus 1 (AXI encoding)
rdata_valid  output  1  read beat available
rdata_ready  input  1  consumer accepts beat
rdata_data  output  DATA_BITS  beat data
rdata_last  output  1  final beat of burst (expected-count based)
done_valid  output  1  one-cycle pulse: burst complete
done_error  output  1  burst saw error; valid with done_valid
axi_ar_valid  output  1  AR valid
axi_ar_ready  input  1  AR ready
axi_ar_bits_addr  output  ADDR_BITS  AR address
axi_ar_bits_len  output  8  AR burst length
axi_ar_bits_size  output  3  constant log2(DATA_BITS/8)
axi_ar_bits_id  output  ID_BITS  constant AXI_ID
axi_r_valid  input  1  R valid
axi_r_ready  output  1  R ready
axi_r_bits_data  input  DATA_BITS  R data
axi_r_bits_resp  input  2  R response
axi_r_bits_last  input  1  R last
axi_r_bits_id  input  ID_BITS  R ID

Behaviour:
Reset:
- One clock; reset is asynchronous and active-low on reset_n.
- While reset_n is low, all outputs are 0, including req_ready, axi_ar_valid, axi_r_ready, rdata_valid and done_valid.
- Reset also sets credits = FIFO_DEPTH, outstanding = 0, and empties the FIFO and the length queue.
- Reset mid-burst discards all state; no partial done is produced.

Request path:
- req_ready = !ar_pending && outstanding < MAX_OUTSTANDING.
- On handshake: latch addr and len, set ar_pending, outstanding += 1, and push len into the in-order length queue (depth MAX_OUTSTANDING).

AR issue:
- In a cycle where ar_pending && !axi_ar_valid && credits >= len+1: raise axi_ar_valid on the next edge and credits -= len+1.
- Otherwise axi_ar_valid stays low.
- The address is passed unmodified. The requester guarantees size alignment and no 4 KB crossing.
- axi_ar_valid and all axi_ar_bits_* are held stable until axi_ar_ready. On handshake: axi_ar_valid = 0 and ar_pending = 0 next cycle.
- Earliest timing: request accepted at edge N, axi_ar_valid high after edge N+1.

R path:
- axi_r_ready = 1 whenever out of reset. The credit reservation guarantees the FIFO never overflows. A push into a full FIFO is a simulation assertion.
- Each R handshake pushes {data, beat == head_len}. The beat counter increments per beat.
- A per-burst error flag is set by any of:
  - resp != 0
  - axi_r_bits_id != AXI_ID
  - axi_r_bits_last != (beat == head_len)
- The burst ends on the beat where beat == head_len, regardless of axi_r_bits_last. On that beat:
  - pop the length queue and clear beat/error;
  - outstanding -= 1;
  - the next cycle, done_valid = 1 for one cycle and done_error = error flag (including the final beat).
- An R beat arriving with the length queue empty or no AR issued: dropped, simulation assertion.

Consumer side:
- FIFO push at edge E gives rdata_valid high after E (1-cycle latency).
- Each pop (rdata_valid && rdata_ready) gives credits += 1.

Simultaneous events:
- Counter updates from the same cycle sum: outstanding ±1, and credits −(len+1) +1.
- A request can be accepted in the cycle a burst completes when outstanding == MAX_OUTSTANDING only if the decrement is already registered. req_ready uses the registered value.
- done_valid is independent of rdata draining; it may precede rdata_last leaving the FIFO.

Test Plan:
1. req addr=0x1000 len=3, slave returns 0xA0..0xA3 OKAY last on beat 4, rdata_ready=1 -> AR addr=0x1000 len=3 size=3 id=0; rdata beats 0xA0..0xA3, rdata_last only on 0xA3; one done_valid with done_error=0.
2. axi_ar_ready held low 5 cycles after AR valid -> axi_ar_valid and addr/len stable all 5 cycles; req_ready low until handshake; single AR.
3. rdata_ready=0, two len=255 requests -> first AR issues, second axi_ar_valid stays low after 256 beats fill FIFO; axi_r_ready never drops. Release rdata_ready -> second AR issues on the cycle after the 256th pop.
4. len=3, beat 2 resp=2 (SLVERR) -> all 4 beats delivered unchanged; done_error=1. Next burst, clean -> done_error=0.
5. len=3, slave asserts r_last on beat 2 and not on beat 4 -> burst still closes after beat 4; rdata_last on beat 4 only; done_error=1.
6. Five back-to-back requests with MAX_OUTSTANDING=4 and slave withholding R -> req_ready low after the fourth. Then reset_n low after 2 beats -> all outputs 0 immediately. After release, a new len=0 read completes with done_error=0.
